// File: rtl/fpga_input_debouncer.sv
// -----------------------------------------------------------------------------
// fpga_input_debouncer
//
// Multi-channel synchroniser and debouncer for raw board inputs (push buttons,
// slide switches). Sits between the FPGA top-level pins and the pad ports that
// carry user inputs, running in the ref_clk domain after the IBUFG.
//
// Each channel passes through a 2-flop synchroniser (raw_i -> s1 -> s2). A
// per-channel counter then qualifies any difference between s2 and the
// current debounced level. A new level is accepted only after it has held for
// STABLE_CYCLES consecutive cycles. Any return to the old level before the
// count completes discards the partial count.
//
// Parameters:
//   NUM_CH         number of independent input channels
//   CNT_W          width of each per-channel stability counter
//   STABLE_CYCLES  consecutive cycles a new level must hold (1 .. 2**CNT_W)
//   RST_VAL        reset value of the synchroniser flops and db_o
//
// Ports:
//   clk_i   in   1       reference clock
//   rst_i   in   1       asynchronous reset, active-high
//   raw_i   in   NUM_CH  raw asynchronous board inputs
//   db_o    out  NUM_CH  debounced level per channel
//   rise_o  out  NUM_CH  1-cycle pulse aligned with a db_o 0->1 change
//   fall_o  out  NUM_CH  1-cycle pulse aligned with a db_o 1->0 change
//   busy_o  out  1       some channel is qualifying a new level
//
// Build option:
//   DEBOUNCE_EDGE_PULSE_EN  defined   -> rise_o/fall_o are registered pulses
//                           undefined -> no edge logic; rise_o/fall_o tied to 0
//   db_o and busy_o timing is the same in both builds.
//
// Handshake: none. All outputs are plain registered levels/pulses sampled on
// the rising edge of clk_i.
// -----------------------------------------------------------------------------
module fpga_input_debouncer #(
    parameter int   NUM_CH        = 7,
    parameter int   CNT_W         = 20,
    parameter int   STABLE_CYCLES = 1000000,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] raw_i,
    output logic [NUM_CH-1:0] db_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic              busy_o
);

    // Counter value at which a differing level is accepted. Comparing against
    // this terminal value (rather than STABLE_CYCLES) keeps the counter from
    // ever needing to represent STABLE_CYCLES itself, so it never wraps.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 1 ||
            longint'(STABLE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_cfg
            $error("fpga_input_debouncer: STABLE_CYCLES must be in 1 .. 2**CNT_W");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // 2-flop synchroniser. Only s2 is used downstream.
    // -------------------------------------------------------------------------
    logic [NUM_CH-1:0] s1;
    logic [NUM_CH-1:0] s2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= {NUM_CH{RST_VAL}};
            s2 <= {NUM_CH{RST_VAL}};
        end else begin
            s1 <= raw_i;
            s2 <= s1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel stability counters
    // -------------------------------------------------------------------------
    logic [NUM_CH-1:0] db_q;
    logic [NUM_CH-1:0] differ;   // s2 disagrees with the debounced level
    logic [NUM_CH-1:0] accept;   // this edge commits s2 into db_q

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [CNT_W-1:0] cnt;

        assign differ[ch] = s2[ch] ^ db_q[ch];
        assign accept[ch] = differ[ch] && (cnt == LAST_CNT);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt <= '0;
            end else if (!differ[ch] || accept[ch]) begin
                // Either the level fell back (glitch/bounce: restart from 0)
                // or it was just accepted (start fresh for the next change).
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Debounced level and busy flag
    // -------------------------------------------------------------------------
    // busy_q records that some channel was counting at the last edge, so it is
    // high from the first counting edge through the accepting edge and drops
    // in the cycle after db_o has changed.
    logic busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            db_q   <= {NUM_CH{RST_VAL}};
            busy_q <= 1'b0;
        end else begin
            // accept implies s2 != db_q, so flipping is the same as loading s2.
            db_q   <= db_q ^ accept;
            busy_q <= |differ;
        end
    end

    assign db_o   = db_q;
    assign busy_o = busy_q;

    // -------------------------------------------------------------------------
    // Optional edge pulses, registered alongside db_q so they line up with the
    // db_o change.
    // -------------------------------------------------------------------------
`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic [NUM_CH-1:0] rise_q;
    logic [NUM_CH-1:0] fall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= accept & ~db_q;
            fall_q <= accept &  db_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule

// File: tb/tb_fpga_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_fpga_input_debouncer
//
// Bench for fpga_input_debouncer with NUM_CH=2, CNT_W=4, STABLE_CYCLES=4,
// RST_VAL=0. Inputs are driven on the falling edge and outputs are sampled on
// the following falling edge, i.e. half a cycle after the active edge.
//
// The reference model keeps a history of raw_i samples. At each edge it takes
// the synchronised sample (two edges old) and flips a channel's level when the
// most recent STABLE_CYCLES synchronised samples all differ from that level.
// -----------------------------------------------------------------------------
module tb_fpga_input_debouncer;

    localparam int   NUM_CH  = 2;
    localparam int   CNT_W   = 4;
    localparam int   STABLE  = 4;
    localparam logic RST_VAL = 1'b0;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    // ---------------------------------------------------------------- clock/reset
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] raw = '0;
    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic              busy;

    always #5 clk = ~clk;

    fpga_input_debouncer #(
        .NUM_CH        (NUM_CH),
        .CNT_W         (CNT_W),
        .STABLE_CYCLES (STABLE),
        .RST_VAL       (RST_VAL)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .raw_i  (raw),
        .db_o   (db),
        .rise_o (rise),
        .fall_o (fall),
        .busy_o (busy)
    );

    // ---------------------------------------------------------------- scoreboard
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [NUM_CH-1:0] act,
                         input logic [NUM_CH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    logic [NUM_CH-1:0] hist[$];   // raw samples, oldest first; prefilled after reset
    logic [NUM_CH-1:0] m_db;
    logic [NUM_CH-1:0] m_rise;
    logic [NUM_CH-1:0] m_fall;
    logic              m_busy;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < STABLE + 2; i++) hist.push_back({NUM_CH{RST_VAL}});
        m_db   = {NUM_CH{RST_VAL}};
        m_rise = '0;
        m_fall = '0;
        m_busy = 1'b0;
    endtask

    // One active edge with rst low. hist ends with the raw value from the
    // previous edge, so the synchronised sample used now is hist[size-2].
    task automatic model_step();
        logic [NUM_CH-1:0] old_db;
        logic [NUM_CH-1:0] s2_now;
        int run;
        old_db = m_db;
        s2_now = hist[hist.size()-2];
        m_rise = '0;
        m_fall = '0;
        m_busy = |(s2_now ^ old_db);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            run = 0;
            for (int k = hist.size() - 2; k >= 0; k--) begin
                if (hist[k][ch] != old_db[ch]) run++;
                else break;
            end
            if (run >= STABLE) begin
                m_db[ch] = ~old_db[ch];
                if (old_db[ch]) m_fall[ch] = 1'b1;
                else            m_rise[ch] = 1'b1;
            end
        end
        hist.push_back(raw);
        while (hist.size() > STABLE + 4) void'(hist.pop_front());
    endtask

    // ---------------------------------------------------------------- driver
    // Advance one cycle and compare the DUT against the model.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check("model_db",   db,   m_db);
        check("model_rise", rise, PULSE_EN ? m_rise : '0);
        check("model_fall", fall, PULSE_EN ? m_fall : '0);
        check("model_busy", {{(NUM_CH-1){1'b0}}, busy}, {{(NUM_CH-1){1'b0}}, m_busy});
    endtask

    // ---------------------------------------------------------------- vector table
    // Each row is driven before an edge; expectations are for just after it.
    // Pulse expectations assume the pulse build and are masked otherwise.
    typedef struct {
        logic              rst;
        logic [NUM_CH-1:0] raw;
        logic [NUM_CH-1:0] db;
        logic [NUM_CH-1:0] rise;
        logic [NUM_CH-1:0] fall;
        logic              busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [NUM_CH-1:0] rw,
                       input logic [NUM_CH-1:0] d, input logic [NUM_CH-1:0] ri,
                       input logic [NUM_CH-1:0] fa, input logic b);
        vec_t v;
        v.rst = r; v.raw = rw; v.db = d; v.rise = ri; v.fall = fa; v.busy = b;
        tbl.push_back(v);
    endtask

    task automatic add_n(input int n, input logic r, input logic [NUM_CH-1:0] rw,
                         input logic [NUM_CH-1:0] d, input logic [NUM_CH-1:0] ri,
                         input logic [NUM_CH-1:0] fa, input logic b);
        for (int i = 0; i < n; i++) add(r, rw, d, ri, fa, b);
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        logic [NUM_CH-1:0] nxt;

        // 1. reset held with raw=11, then release
        add_n(5, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        add_n(2, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        // 2. clean step on ch0: busy after edges 3..6, db/rise at edge 6
        add_n(2, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        add_n(3, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
        add  (   1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1);
        add_n(2, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        // back to a clean zero state
        add  (   1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        // 3. bounce: high 3, low 1, high; accepted at edge 10
        add_n(2, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        add  (   1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
        add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        add  (   1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
        add  (   1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        add_n(3, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
        add  (   1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1);
        add_n(2, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        // 4. release ch0: fall pulse 6 edges after raw drops
        add_n(2, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        add_n(3, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1);
        add  (   1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1);
        add_n(2, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        // 5. both channels step together
        add_n(2, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        add_n(3, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
        add  (   1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1);
        add  (   1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);

        model_reset();
        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            raw = tbl[i].raw;
            tick();
            check($sformatf("vec%0d_db", i),   db,   tbl[i].db);
            check($sformatf("vec%0d_rise", i), rise, PULSE_EN ? tbl[i].rise : '0);
            check($sformatf("vec%0d_fall", i), fall, PULSE_EN ? tbl[i].fall : '0);
            check($sformatf("vec%0d_busy", i), {1'b0, busy}, {1'b0, tbl[i].busy});
        end

        // 5b. reset in the middle of a falling qualification from db=11
        raw = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        check("midcnt_busy", {1'b0, busy}, 2'b01);
        rst = 1'b1;
        #1;
        check("async_rst_db",   db,            2'b00);
        check("async_rst_busy", {1'b0, busy},  2'b00);
        check("async_rst_fall", fall,          2'b00);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_exit_db",    db,   2'b00);
            check("rst_exit_pulse", rise | fall, 2'b00);
        end

        // Random phases: fast toggling (mostly bounces) then slower toggling
        // (frequent acceptances), with occasional resets.
        for (int phase = 0; phase < 3; phase++) begin
            for (int cyc = 0; cyc < 400; cyc++) begin
                nxt = raw;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if ($urandom_range(0, 2 + phase * 5) == 0) nxt[ch] = ~nxt[ch];
                end
                raw = nxt;
                rst = ($urandom_range(0, 149) == 0);
                tick();
            end
        end
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
